// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the non-blocking memory stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Per-entry control bits; wide fields (payload, off, result, data) live in parallel arrays.
    typedef struct packed {
        logic  valid;
        logic  mem_req;
        logic  is_load;
        size_e size;
        logic  uns;
        logic  got;
    } entry_ctrl_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data lane select and sign/zero extension for any DATA_W.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned  DATA_W = 32,
    localparam int unsigned OFF_W  = clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data_i,
    input  size_e             size_i,
    input  logic              uns_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic [DATA_W-1:0] wdata_c
);

    logic [OFF_W-1:0]  lane_off;
    logic [DATA_W-1:0] shifted;
    logic              sign;

    // Pick the naturally aligned lane, then extend with sign = ~uns & msb.
    always_comb begin
        lane_off = off_i;
        unique case (size_i)
            SZ_B:    lane_off = off_i;
            SZ_H:    lane_off = off_i & ~OFF_W'(1);
            default: lane_off = off_i & ~OFF_W'(3);
        endcase
        shifted = data_i >> {lane_off, 3'b000};
        sign    = 1'b0;
        wdata_c = shifted;
        unique case (size_i)
            SZ_B: begin
                sign    = ~uns_i & shifted[7];
                wdata_c = DATA_W'($signed({sign, shifted[7:0]}));
            end
            SZ_H: begin
                sign    = ~uns_i & shifted[15];
                wdata_c = DATA_W'($signed({sign, shifted[15:0]}));
            end
            SZ_W: begin
                sign    = ~uns_i & shifted[31];
                wdata_c = DATA_W'($signed({sign, shifted[31:0]}));
            end
            default: begin
                // A dword on a 32-bit datapath degenerates to a word.
                if (DATA_W >= 64) begin
                    wdata_c = data_i;
                end else begin
                    sign    = ~uns_i & shifted[31];
                    wdata_c = DATA_W'($signed({sign, shifted[31:0]}));
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_nb.sv
// Non-blocking MEM stage: in-order queue of in-flight instructions with
// in-order response binding and post-flush response cancellation.
module mem_stage_nb
    import mem_stage_pkg::*;
#(
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  DEPTH     = 2,
    parameter int unsigned  PAYLOAD_W = 200,
    localparam int unsigned OFF_W     = clog2(DATA_W / 8)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_mem_req,
    input  logic                 in_is_load,
    input  logic [1:0]           in_size,
    input  logic                 in_unsigned,
    input  logic [OFF_W-1:0]     in_off,
    input  logic [DATA_W-1:0]    in_result,
    input  logic                 data_ok,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [DATA_W-1:0]    out_wdata,
    output logic                 pending
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = clog2(DEPTH + 1);
    localparam int unsigned CAN_W   = clog2(2 * DEPTH + 1);
    localparam int unsigned CAN_MAX = 2 * DEPTH;

    entry_ctrl_t          ctrl_q    [DEPTH];
    entry_ctrl_t          ctrl_d    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [OFF_W-1:0]     off_q     [DEPTH];
    logic [OFF_W-1:0]     off_d     [DEPTH];
    logic [DATA_W-1:0]    result_q  [DEPTH];
    logic [DATA_W-1:0]    result_d  [DEPTH];
    logic [DATA_W-1:0]    data_q    [DEPTH];
    logic [DATA_W-1:0]    data_d    [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CAN_W-1:0]     cancel_q, cancel_d;

    entry_ctrl_t          head_ctrl;
    logic                 head_complete;
    logic                 pop;
    logic                 push;
    logic                 owner_found;
    logic [PTR_W-1:0]     owner_idx;
    logic [PTR_W-1:0]     slot;
    int unsigned          outstanding;
    int unsigned          cancel_sum;
    logic                 cancel_ovf;
    logic [DATA_W-1:0]    head_aligned_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .data_i  (data_q[head_q]),
        .size_i  (head_ctrl.size),
        .uns_i   (head_ctrl.uns),
        .off_i   (off_q[head_q]),
        .wdata_c (head_aligned_c)
    );

    // Head presentation and handshakes; flush suppresses both push and pop.
    always_comb begin
        head_ctrl     = ctrl_q[head_q];
        head_complete = ~head_ctrl.mem_req | head_ctrl.got;
        out_valid     = head_ctrl.valid & head_complete & ~flush;
        pop           = out_valid & out_ready;
        in_ready      = ~flush & ((32'(count_q) < DEPTH) | pop);
        push          = in_valid & in_ready;
        out_payload   = payload_q[head_q];
        out_wdata     = head_ctrl.is_load ? head_aligned_c : result_q[head_q];
    end

    // Oldest entry still owed a response, and the total number owed.
    always_comb begin
        owner_found = 1'b0;
        owner_idx   = '0;
        slot        = '0;
        outstanding = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = PTR_W'((32'(head_q) + i) % DEPTH);
            if (ctrl_q[slot].valid && ctrl_q[slot].mem_req && !ctrl_q[slot].got) begin
                outstanding = outstanding + 1;
                if (!owner_found) begin
                    owner_found = 1'b1;
                    owner_idx   = slot;
                end
            end
        end
        pending = (outstanding != 0) || (cancel_q != '0);
    end

    // Queue, binding and cancel-count next state.
    always_comb begin
        ctrl_d     = ctrl_q;
        payload_d  = payload_q;
        off_d      = off_q;
        result_d   = result_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        cancel_d   = cancel_q;
        cancel_sum = 32'(cancel_q);
        cancel_ovf = 1'b0;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_d[PTR_W'(i)].valid = 1'b0;
            end
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            cancel_sum = 32'(cancel_q) + outstanding;
            if (data_ok && cancel_sum != 0) begin
                cancel_sum = cancel_sum - 1;
            end
            if (cancel_sum > CAN_MAX) begin
                cancel_ovf = 1'b1;
                cancel_sum = CAN_MAX;
            end
            cancel_d = CAN_W'(cancel_sum);
        end else begin
            if (data_ok) begin
                if (cancel_q != '0) begin
                    cancel_d = cancel_q - CAN_W'(1);
                end else if (owner_found) begin
                    ctrl_d[owner_idx].got = 1'b1;
                    data_d[owner_idx]     = rdata;
                end
            end
            if (pop) begin
                ctrl_d[head_q].valid = 1'b0;
                head_d               = ptr_inc(head_q);
            end
            if (push) begin
                ctrl_d[tail_q].valid   = 1'b1;
                ctrl_d[tail_q].mem_req = in_mem_req;
                ctrl_d[tail_q].is_load = in_is_load;
                ctrl_d[tail_q].size    = size_e'(in_size);
                ctrl_d[tail_q].uns     = in_unsigned;
                ctrl_d[tail_q].got     = 1'b0;
                payload_d[tail_q]      = in_payload;
                off_d[tail_q]          = in_off;
                result_d[tail_q]       = in_result;
                tail_d                 = ptr_inc(tail_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; reset forgets all in-flight and cancelled responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_q[PTR_W'(i)]    <= '0;
                payload_q[PTR_W'(i)] <= '0;
                off_q[PTR_W'(i)]     <= '0;
                result_q[PTR_W'(i)]  <= '0;
                data_q[PTR_W'(i)]    <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cancel_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            payload_q <= payload_d;
            off_q     <= off_d;
            result_q  <= result_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            cancel_q  <= cancel_d;
        end
    end

    // A response must belong to a live entry or to a cancelled one.
    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!resetn)
        data_ok |-> ((cancel_q != '0) || owner_found));

    a_cancel_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !cancel_ovf);

endmodule

// File: doc/mem_stage_nb.md
# mem_stage_nb

Non-blocking memory pipeline stage between EX and WB. It holds up to `DEPTH` in-flight instructions in program order, so several data-SRAM requests can be outstanding at once. Load responses are bound in order, then aligned and sign- or zero-extended for any `DATA_W`. After a flush it discards the responses that were still owed to flushed instructions.

## Interface
Parameters:
- `DATA_W`, default 32: data width, 32 or 64.
- `DEPTH`, default 2: in-flight entries (≥1).
- `PAYLOAD_W`, default 200: opaque pass-through bits (pc, rf write info, CSR/exception fields).
- `OFF_W`, derived: log2(`DATA_W`/8).

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, **asynchronous, active-low**; one clock.
- `in_valid`  in  1  EX presents an instruction.
- `in_ready`  out  1  stage accepts (allowin).
- `in_payload`  in  `PAYLOAD_W`  pass-through bits.
- `in_mem_req`  in  1  the instruction issued a data request and waits for `data_ok`.
- `in_is_load`  in  1  the response data is the result.
- `in_size`  in  2  00 byte, 01 half, 10 word, 11 dword (11 is treated as word when `DATA_W`=32).
- `in_unsigned`  in  1  zero-extend instead of sign-extend.
- `in_off`  in  `OFF_W`  low address bits.
- `in_result`  in  `DATA_W`  ALU or counter result.
- `data_ok`  in  1  one in-order data response.
- `rdata`  in  `DATA_W`  response data.
- `flush`  in  1  exception/ertn flush.
- `out_valid`  out  1  head is complete.
- `out_ready`  in  1  WB allowin.
- `out_payload`  out  `PAYLOAD_W`  head payload.
- `out_wdata`  out  `DATA_W`  head rf write data.
- `pending`  out  1  outstanding or cancelled responses exist.

## Operation
- **Queue:** circular FIFO of `DEPTH` entries. Each entry holds {payload, mem_req, is_load, size, unsigned, off, result, got, data}. Push pointer and pop pointer are `DEPTH`-modulo and wrap at `DEPTH`-1 back to 0.
- **Push:** a push occurs on `in_valid & in_ready`.
- **`in_ready`:** `in_ready = (count < DEPTH) | pop`, so a simultaneous push and pop while full is allowed.
- **Response binding:** `data_ok` is assigned to the oldest entry with `mem_req & ~got`, unless `cancel_cnt` > 0. In that case `cancel_cnt` is decremented and the data is dropped. When `data_ok` arrives with no owner, it is dropped and a simulation assertion fires.
- **Head complete:** the head is complete when `~mem_req | got`.
- **`out_valid`:** `out_valid = head_valid & complete`.
- **Pop:** a pop occurs on `out_valid & out_ready`.
- **`out_wdata`:** equals `align(data)` for a load; otherwise `result`.
- **Alignment:**
  - byte lane = `off`; half lane = `off` with bit0 ignored; word lane = `off` with bits[1:0] ignored.
  - The lane is extended to `DATA_W` with sign bit `~unsigned & msb`.
- **Flush:**
  - All entries are invalidated next cycle; `count` becomes 0.
  - `cancel_cnt` += number of entries with `mem_req & ~got`. If a `data_ok` arrives in the same cycle, it consumes one of those and is dropped.
  - `in_valid` in the flush cycle is not accepted; `in_ready` is forced to 0 that cycle.
- **`cancel_cnt`:** width log2(2·`DEPTH`+1), saturates at 2·`DEPTH` and asserts on overflow.
- **`pending`:** `(outstanding | cancel_cnt) != 0`.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_payload`=0, `out_wdata`=0, `pending`=0; `count`=0, `cancel_cnt`=0.
- **Latency:**
  - Non-memory instruction: pushed in cycle N, `out_valid` in N+1.
  - Memory instruction: `data_ok` in cycle M binds the entry, `out_valid` in M+1 at the earliest. `rdata` is registered; there is no combinational `data_ok`→`out_valid` path.
- **Hold:** outputs stay stable while `out_valid & ~out_ready`.
- **Reset mid-operation:** all state clears asynchronously, and outstanding responses are forgotten. The bus is reset as well, so no late responses follow.
- **Combined events:** `flush` with `pop` in the same cycle: no pop is reported to WB; `flush` wins.

## Structure
- Package `mem_stage_pkg`:
  - `size_e` enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`).
  - Entry struct typedef.
  - `clog2` helper.
- Sub-module `load_align`: combinational lane select plus extend, parametrised by `DATA_W`. It is used once on the head entry.

## Test plan
- **Non-memory pass-through:** `DEPTH`=2, two non-memory pushes back-to-back with `out_ready`=1 → `out_valid` in cycles N+1 and N+2, payloads in order.
- **Load alignment:** load byte signed, `off`=3, `rdata`=0x80_00_00_00 → `out_wdata`=0xFFFF_FF80. Half unsigned, `off`=2 → 0x0000_8000. `DATA_W`=64 dword → full `rdata`.
- **Two outstanding loads:** pushed, `out_ready`=0. `data_ok` twice (0x11, 0x22) → head wdata 0x11. Raise `out_ready` → 0x11 then 0x22. `in_ready`=0 while full without a pop.
- **Flush with outstanding requests:** two outstanding requests, flush → `cancel_cnt`=2, `out_valid`=0. New load pushed, then three `data_ok` (0xA, 0xB, 0xC) → first two dropped, new load outputs 0xC.
- **Flush plus `data_ok`:** flush and `data_ok` in the same cycle with one outstanding → `cancel_cnt` stays 0, `pending`=0 next cycle.
- **Full boundary and reset:** full queue with simultaneous push and pop → accepted, `count` stays `DEPTH`, pointers wrap. Assert `resetn`=0 mid-run → all outputs at reset values immediately.
